// File: rtl/icon_pkg.sv
// -----------------------------------------------------------------------------
// icon_pkg
// Shared definitions for the multi-bot icon overlay: heading encodings, colour
// indices, pipeline latency, the per-bot shadow record and the icon image
// contents used by icon_rom.
// -----------------------------------------------------------------------------
package icon_pkg;

    localparam int unsigned PIPE_LATENCY = 2;   // pixel sample -> icon output
    localparam int unsigned COORD_W      = 14;  // signed display-space width
    localparam int unsigned OFF_W        = 5;   // icon offset width (ICON_SIZE <= 32)

    localparam logic [1:0] TRANSPARENT = 2'b00;
    localparam logic [1:0] COL_BODY    = 2'b01;
    localparam logic [1:0] COL_EDGE    = 2'b10;
    localparam logic [1:0] COL_NOSE    = 2'b11;

    // Heading in 45-degree steps, clockwise from north
    typedef enum logic [2:0] {
        HEAD_N  = 3'd0,
        HEAD_NE = 3'd1,
        HEAD_E  = 3'd2,
        HEAD_SE = 3'd3,
        HEAD_S  = 3'd4,
        HEAD_SW = 3'd5,
        HEAD_W  = 3'd6,
        HEAD_NW = 3'd7
    } heading_e;

    // Per-bot values latched at frame start
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       enable;
        heading_e   heading;
    } bot_shadow_t;

    // Image contents: colour = bits [2:1] of (5*row + 3*col + heading)
    function automatic logic [1:0] rom_pixel(input heading_e         heading,
                                             input logic [OFF_W-1:0] row,
                                             input logic [OFF_W-1:0] col);
        logic [7:0] sum;
        sum = 8'(row) * 8'd5 + 8'(col) * 8'd3 + 8'(heading);
        return sum[2:1];
    endfunction

endpackage

// File: rtl/icon_rom.sv
// -----------------------------------------------------------------------------
// icon_rom
// Eight-heading ICON_SIZE x ICON_SIZE x 2-bit icon image store, one synchronous
// read port.
//   clk, reset  : clock, synchronous active-high reset
//   heading_i   : image select
//   row_i/col_i : pixel offset inside the icon
//   pix_o       : registered colour index (valid one cycle after address)
// -----------------------------------------------------------------------------
module icon_rom
    import icon_pkg::*;
#(
    parameter int unsigned ICON_SIZE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  heading_e         heading_i,
    input  logic [OFF_W-1:0] row_i,
    input  logic [OFF_W-1:0] col_i,
    output logic [1:0]       pix_o
);

    localparam logic [OFF_W-1:0] ADDR_MASK = OFF_W'(ICON_SIZE - 1);

    logic [1:0] pix_q;

    // Synchronous read
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q <= TRANSPARENT;
        end else begin
            pix_q <= rom_pixel(heading_i, row_i & ADDR_MASK, col_i & ADDR_MASK);
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/multi_icon.sv
// -----------------------------------------------------------------------------
// multi_icon
// Overlays up to eight bot icons on a video stream. Bot positions/info are
// shadowed at frame start; each pixel passes a two-stage pipeline (hit/offset
// compare with ROM address issue, then ROM data + priority mux).
// Optional feature macro: ICON_BLINK_EN (frame counter + per-bot blink).
//   clk, reset          : clock, synchronous active-high reset
//   frame_start         : one-cycle pulse, latches bot registers
//   locXReg/locYReg     : packed 8-bit world X/Y per bot
//   botInfoReg          : packed info per bot ([2:0] heading, [6] en, [7] blink)
//   pixel_row/column    : current display pixel
//   icon, icon_id       : colour index and winning bot, 2 cycles later
// -----------------------------------------------------------------------------
module multi_icon
    import icon_pkg::*;
#(
    parameter int unsigned NUM_BOTS  = 4,
    parameter int unsigned ICON_SIZE = 16,
    parameter int unsigned COL_SHIFT = 3,
    parameter int unsigned ROW_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [8*NUM_BOTS-1:0] locXReg,
    input  logic [8*NUM_BOTS-1:0] locYReg,
    input  logic [8*NUM_BOTS-1:0] botInfoReg,
    input  logic [11:0]           pixel_row,
    input  logic [11:0]           pixel_column,
    output logic [1:0]            icon,
    output logic [2:0]            icon_id
);

    bot_shadow_t shadow_q [NUM_BOTS];

    // Shadow registers: only updated on frame_start so a frame never tears
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(NUM_BOTS); k++) begin
                shadow_q[k] <= '0;
            end
        end else if (frame_start) begin
            for (int k = 0; k < int'(NUM_BOTS); k++) begin
                shadow_q[k].x       <= locXReg[8*k +: 8];
                shadow_q[k].y       <= locYReg[8*k +: 8];
                shadow_q[k].enable  <= botInfoReg[8*k+6];
                shadow_q[k].heading <= heading_e'(botInfoReg[8*k +: 3]);
            end
        end
    end

    logic [NUM_BOTS-1:0] blink_ok;

`ifdef ICON_BLINK_EN
    logic [7:0]          frame_cnt_q;
    logic [NUM_BOTS-1:0] blink_q;

    // Frame counter and blink requests, latched alongside the shadows
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= 8'd0;
            blink_q     <= '0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
            for (int k = 0; k < int'(NUM_BOTS); k++) begin
                blink_q[k] <= botInfoReg[8*k+7];
            end
        end
    end

    // Blinking bots are hidden during the 16 frames where counter bit 4 is low
    always_comb begin
        for (int k = 0; k < int'(NUM_BOTS); k++) begin
            blink_ok[k] = !(blink_q[k] && !frame_cnt_q[4]);
        end
    end
`else
    assign blink_ok = '1;
`endif

    // Info bits that carry no meaning in this build
    logic [NUM_BOTS-1:0] unused_info;
    always_comb begin
        for (int k = 0; k < int'(NUM_BOTS); k++) begin
`ifdef ICON_BLINK_EN
            unused_info[k] = ^botInfoReg[8*k+3 +: 3];
`else
            unused_info[k] = ^{botInfoReg[8*k+7], botInfoReg[8*k+3 +: 3]};
`endif
        end
    end

    // Stage 1: signed origin/offset compare; offsets also address the ROMs
    logic signed [COORD_W-1:0] col0 [NUM_BOTS];
    logic signed [COORD_W-1:0] row0 [NUM_BOTS];
    logic signed [COORD_W-1:0] dcol [NUM_BOTS];
    logic signed [COORD_W-1:0] drow [NUM_BOTS];
    logic [OFF_W-1:0]          off_col [NUM_BOTS];
    logic [OFF_W-1:0]          off_row [NUM_BOTS];
    logic [NUM_BOTS-1:0]       hit_d;
    logic [NUM_BOTS-1:0]       hit_q;

    always_comb begin
        for (int k = 0; k < int'(NUM_BOTS); k++) begin
            col0[k] = $signed(COORD_W'(shadow_q[k].x) << COL_SHIFT)
                    - $signed(COORD_W'(ICON_SIZE / 2));
            row0[k] = $signed(COORD_W'(shadow_q[k].y) << ROW_SHIFT)
                    - $signed(COORD_W'(ICON_SIZE / 2));
            dcol[k] = $signed({2'b00, pixel_column}) - col0[k];
            drow[k] = $signed({2'b00, pixel_row}) - row0[k];
            off_col[k] = OFF_W'(dcol[k]);
            off_row[k] = OFF_W'(drow[k]);
            hit_d[k] = shadow_q[k].enable && blink_ok[k]
                    && (dcol[k] >= 0) && (dcol[k] < $signed(COORD_W'(ICON_SIZE)))
                    && (drow[k] >= 0) && (drow[k] < $signed(COORD_W'(ICON_SIZE)));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    logic [1:0] rom_pix [NUM_BOTS];

    for (genvar k = 0; k < int'(NUM_BOTS); k++) begin : g_rom
        icon_rom #(
            .ICON_SIZE (ICON_SIZE)
        ) u_rom (
            .clk       (clk),
            .reset     (reset),
            .heading_i (shadow_q[k].heading),
            .row_i     (off_row[k]),
            .col_i     (off_col[k]),
            .pix_o     (rom_pix[k])
        );
    end

    // Stage 2: lowest-index opaque pixel wins; scan high to low so it lands last
    logic [1:0] icon_d;
    logic [2:0] icon_id_d;
    logic [1:0] icon_q;
    logic [2:0] icon_id_q;

    always_comb begin
        icon_d    = TRANSPARENT;
        icon_id_d = 3'd0;
        for (int k = int'(NUM_BOTS) - 1; k >= 0; k--) begin
            if (hit_q[k] && (rom_pix[k] != TRANSPARENT)) begin
                icon_d    = rom_pix[k];
                icon_id_d = 3'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            icon_q    <= TRANSPARENT;
            icon_id_q <= 3'd0;
        end else begin
            icon_q    <= icon_d;
            icon_id_q <= icon_id_d;
        end
    end

    assign icon    = icon_q;
    assign icon_id = icon_id_q;

endmodule

// File: tb/tb_multi_icon.sv
// -----------------------------------------------------------------------------
// tb_multi_icon
// Self-checking bench for multi_icon: a behavioural model predicts every output
// pixel from the shadowed bot state; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_multi_icon;

    localparam int NB = 4;
    localparam int IS = 16;
    localparam int CS = 3;
    localparam int RS = 3;
`ifdef ICON_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_start;
    logic [8*NB-1:0] locXReg;
    logic [8*NB-1:0] locYReg;
    logic [8*NB-1:0] botInfoReg;
    logic [11:0]     pixel_row;
    logic [11:0]     pixel_column;
    logic [1:0]      icon;
    logic [2:0]      icon_id;

    always #5 clk = ~clk;

    multi_icon #(
        .NUM_BOTS  (NB),
        .ICON_SIZE (IS),
        .COL_SHIFT (CS),
        .ROW_SHIFT (RS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .locXReg      (locXReg),
        .locYReg      (locYReg),
        .botInfoReg   (botInfoReg),
        .pixel_row    (pixel_row),
        .pixel_column (pixel_column),
        .icon         (icon),
        .icon_id      (icon_id)
    );

    // Model state: what the display should be drawing from
    int         sh_x [NB];
    int         sh_y [NB];
    int         sh_h [NB];
    bit         sh_en [NB];
    bit         sh_bl [NB];
    int         frame_cnt;
    logic [4:0] exp1;
    logic [4:0] exp2;
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         check_en = 1'b0;

    // Expected {icon_id, icon} for a display pixel
    function automatic logic [4:0] model_pixel(input int r, input int c);
        for (int k = 0; k < NB; k++) begin
            int dr;
            int dc;
            int v;
            if (!sh_en[k]) continue;
            if (BLINK && sh_bl[k] && ((frame_cnt / 16) % 2 == 0)) continue;
            dr = r - (sh_y[k] * (1 << RS) - IS / 2);
            dc = c - (sh_x[k] * (1 << CS) - IS / 2);
            if (dr < 0 || dr >= IS || dc < 0 || dc >= IS) continue;
            v = ((5 * dr + 3 * dc + sh_h[k]) / 2) % 4;
            if (v != 0) return {3'(k), 2'(v)};
        end
        return 5'd0;
    endfunction

    always @(posedge clk) begin
        exp2 = exp1;
        exp1 = model_pixel(int'(pixel_row), int'(pixel_column));
        if (reset) begin
            exp1 = 5'd0;
            exp2 = 5'd0;
            frame_cnt = 0;
            for (int k = 0; k < NB; k++) begin
                sh_x[k] = 0; sh_y[k] = 0; sh_h[k] = 0; sh_en[k] = 0; sh_bl[k] = 0;
            end
        end else if (frame_start) begin
            frame_cnt = (frame_cnt + 1) % 256;
            for (int k = 0; k < NB; k++) begin
                sh_x[k]  = int'(locXReg[8*k +: 8]);
                sh_y[k]  = int'(locYReg[8*k +: 8]);
                sh_h[k]  = int'(botInfoReg[8*k +: 3]);
                sh_en[k] = botInfoReg[8*k+6];
                sh_bl[k] = botInfoReg[8*k+7];
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (check_en) begin
            n_checks++;
            if ({icon_id, icon} === exp2) begin
                n_pass++;
            end else begin
                $display("FAIL pipe t=%0t: icon=%0d id=%0d, expected icon=%0d id=%0d",
                         $time, icon, icon_id, exp2[1:0], exp2[4:2]);
            end
        end
    end

    task automatic step(input int r, input int c, input bit fs);
        @(negedge clk);
        pixel_row    = 12'(r);
        pixel_column = 12'(c);
        frame_start  = fs;
    endtask

    task automatic set_bot(input int k, input int x, input int y, input logic [7:0] info);
        locXReg[8*k +: 8]    = 8'(x);
        locYReg[8*k +: 8]    = 8'(y);
        botInfoReg[8*k +: 8] = info;
    endtask

    task automatic check_lit(input string name, input int r, input int c, input bit fs,
                             input logic [1:0] ei, input logic [2:0] eid);
        step(r, c, fs);
        step(4095, 4095, 0);
        @(negedge clk);
        n_checks++;
        if (icon === ei && icon_id === eid) begin
            n_pass++;
        end else begin
            $display("FAIL %s: icon=%0d id=%0d, expected icon=%0d id=%0d",
                     name, icon, icon_id, ei, eid);
        end
    endtask

    initial begin
        reset        = 1'b1;
        frame_start  = 1'b0;
        pixel_row    = '0;
        pixel_column = '0;
        locXReg      = '0;
        locYReg      = '0;
        botInfoReg   = '0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        check_lit("reset_idle", 8, 8, 0, 2'd0, 3'd0);
        reset = 1'b0;

        // Single bot at (2,2) heading 2: icon covers rows/cols 8..23
        set_bot(0, 2, 2, 8'h42);
        step(0, 0, 1);
        check_lit("b0_origin", 8, 8, 0, 2'd1, 3'd0);
        check_lit("b0_r1c0",   9, 8, 0, 2'd3, 3'd0);
        check_lit("b0_r0c1",   8, 9, 0, 2'd2, 3'd0);
        check_lit("b0_last",  23, 23, 0, 2'd1, 3'd0);
        check_lit("b0_below", 24, 23, 0, 2'd0, 3'd0);
        check_lit("b0_left",   8, 7, 0, 2'd0, 3'd0);
        for (int r = 3; r <= 27; r++)
            for (int c = 4; c <= 36; c++)
                step(r, c, 0);

        // Mid-frame move is invisible until frame_start; coincident pixel uses old state
        set_bot(0, 50, 2, 8'h42);
        for (int i = 0; i < 40; i++) step(8 + i % 16, 8 + i, 0);
        check_lit("no_tear", 8, 9, 0, 2'd2, 3'd0);
        check_lit("fs_same_cycle", 8, 9, 1, 2'd2, 3'd0);
        check_lit("moved_old_spot", 8, 9, 0, 2'd0, 3'd0);
        check_lit("moved_new", 8, 393, 0, 2'd2, 3'd0);

        // Overlap priority
        set_bot(0, 10, 10, 8'h40);
        set_bot(1, 10, 10, 8'h41);
        step(0, 0, 1);
        check_lit("prio_b0", 72, 73, 0, 2'd1, 3'd0);
        check_lit("prio_b1", 72, 75, 0, 2'd1, 3'd1);
        for (int r = 70; r <= 90; r++)
            for (int c = 70; c <= 90; c++)
                step(r, c, 0);

        // Clipping at the origin, no wrap to the far edge
        set_bot(1, 0, 0, 8'h00);
        set_bot(0, 0, 0, 8'h40);
        step(0, 0, 1);
        check_lit("clip_in",    0, 1, 0, 2'd1, 3'd0);
        check_lit("clip_col8",  0, 8, 0, 2'd0, 3'd0);
        check_lit("no_wrap",    4095, 4095, 0, 2'd0, 3'd0);
        check_lit("no_wrap_r",  4090, 1, 0, 2'd0, 3'd0);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 20; c++)
                step((r < 10) ? r : 4078 + r, (c < 10) ? c : 4078 + c, 0);

        // Reset while icon is drawn
        set_bot(0, 2, 2, 8'h42);
        step(0, 0, 1);
        step(8, 9, 0);
        step(8, 9, 0);
        step(8, 9, 0);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (icon === 2'd0 && icon_id === 3'd0) n_pass++;
        else $display("FAIL reset_clears: icon=%0d id=%0d, expected icon=0 id=0", icon, icon_id);
        reset = 1'b0;
        check_lit("post_reset", 8, 9, 0, 2'd0, 3'd0);
        for (int i = 0; i < 30; i++) step(8 + i % 16, 8 + i % 16, 0);
        step(0, 0, 1);
        check_lit("after_fs", 8, 9, 0, 2'd2, 3'd0);

`ifdef ICON_BLINK_EN
        // Blink: absent for counter frames 0..15, present 16..31
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        set_bot(0, 2, 2, 8'hC2);
        for (int f = 0; f < 40; f++) begin
            step(0, 0, 1);
            for (int i = 0; i < 6; i++) step(8, 8 + i, 0);
        end
`endif

        // Randomised frames with mid-frame updates
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < NB; k++)
                set_bot(k, $urandom_range(0, 127), $urandom_range(0, 127),
                        8'($urandom) | (($urandom % 4 != 0) ? 8'h40 : 8'h00));
            step(0, 0, 1);
            for (int i = 0; i < 400; i++) begin
                int k;
                int r;
                int c;
                k = $urandom_range(0, NB - 1);
                r = int'(locYReg[8*k +: 8]) * 8 + $urandom_range(0, 27) - 10;
                c = int'(locXReg[8*k +: 8]) * 8 + $urandom_range(0, 27) - 10;
                if ($urandom % 13 == 0)
                    locXReg[8*k +: 8] = 8'($urandom_range(0, 127));
                step(r, c, ($urandom % 97) == 0);
            end
        end

        step(0, 0, 0);
        step(0, 0, 0);
        @(negedge clk);
        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
